bullets_pool: RTL and testbench
===============================

# bullets_pool

Fixed pool of three player bullets that the game logic fires, moves once per frame and retires on collision or at the screen top. For the current VGA pixel it produces a per-slot bullet drawing request and the bullet colour, which feed the bullet input pair of the objects mux. All state changes happen on frame boundaries or on collision, so the pool is stable while a frame is scanned.

## Interface
- NUM_BULLETS, 3, slot count; fixed, must match the 3-bit drawing-request width
- BULLET_W, 4, bullet width in pixels
- BULLET_H, 8, bullet height in pixels
- SPEED, 4, upward pixels per frame
- X_OFFSET, 14, spawn x offset from shooterX
- COOLDOWN_FRAMES, 8, frames after a spawn during which fire is ignored
- BULLET_COLOR, 8'hFC, RRRGGGBB bullet colour (yellow)

Ports:
- clk  in  1  pixel clock
- resetN  in  1  reset; synchronous, active-low
- startOfFrame  in  1  one-cycle pulse per frame
- fire  in  1  level fire request (key), not debounced here
- shooterX, shooterY  in  11 each  shooter top-left
- pixelX, pixelY  in  11 each  current scan pixel
- hit  in  3  per-slot collision, retire slot
- bulletDrawingRequest  out  3  bit i = pixel inside active slot i
- bulletRGB  out  8  colour for the current pixel
- shotFired  out  1  one-cycle pulse on spawn

## Operation
- Slot state: IDLE or FLYING, plus 11-bit x and y. Reset: all slots IDLE, x = y = 0.
- Fire edge: a rising edge of fire (previous value registered) sets `pending`. Edges while the cooldown is nonzero are dropped.
- On startOfFrame, evaluate in this order:
  - Hit: slot i with hit[i]=1 goes IDLE and does not move.
  - Move: each other FLYING slot with y ≥ SPEED gets y -= SPEED. A FLYING slot with y < SPEED goes IDLE.
  - Spawn: if pending and any slot was IDLE at the start of this cycle, the lowest-index such slot goes FLYING.
    - Spawn x = shooterX + X_OFFSET, clamped to 640−BULLET_W when the 12-bit sum exceeds that value.
    - Spawn y = shooterY − BULLET_H, saturating at 0.
    - On spawn: shotFired pulses, cooldown loads COOLDOWN_FRAMES.
  - pending clears on every startOfFrame, whether or not a spawn happened. If no slot is free, the shot is lost.
- Between frames: hit[i] clears slot i on the next clock. A FLYING slot never moves outside startOfFrame.
- Cooldown: decrements by 1 per startOfFrame while nonzero. A load on spawn overrides the decrement in the same cycle.
- Drawing: bulletDrawingRequest[i] = FLYING[i] && x ≤ pixelX < x+BULLET_W && y ≤ pixelY < y+BULLET_H.
  - Compare in 12-bit unsigned so x+W never wraps.
- bulletRGB = BULLET_COLOR when any request bit is set, else 8'h00.

## Timing
- All outputs are registered, with one-cycle latency from pixelX/pixelY. The pixel generator compensates for this latency the same way it does for every other object.
- Reset values: bulletDrawingRequest = 0, bulletRGB = 0, shotFired = 0, pending = 0, cooldown = 0.
- resetN low in any cycle, including mid-frame or mid-flight, clears all state on that edge.
- Fire edge at cycle n: pending at n+1. The spawn happens at the first startOfFrame at or after n+1. The bullet draws from the frame following that pulse.
- hit at cycle n: drawing request for that slot is 0 from cycle n+2 onward.
- hit[i] on an IDLE slot has no effect.
- Simultaneous hit on slot 0 and spawn: slot 0 was FLYING at cycle start, so the spawn goes to the next IDLE slot. If no slot is IDLE, the shot is lost.

## Structure
- Package bullets_pkg holds:
  - NUM_BULLETS and screen constants (640×480).
  - typedef slot_t {logic active; logic [10:0] x; logic [10:0] y;}.
  - Default colour constant.
- Sub-module bullet_slot, instantiated NUM_BULLETS times. Each instance holds one slot_t and does move, top-exit, hit and the box compare for its request bit.
- Top level holds fire-edge detection, pending, cooldown, the lowest-free-slot priority encoder, spawn coordinate arithmetic and the colour/request output registers.

## Test plan
- Reset then idle frames: all outputs 0. A fire edge with shooter at (300,400) spawns slot 0 at (314,392) on the next startOfFrame, and shotFired pulses once.
- Flight: after 10 further frames slot 0 is at y=352. Pixel (315,355) gives request 3'b001 and RGB 8'hFC one cycle later. Pixel (318,355) gives 0.
- Top exit: spawn with shooterY=10 (y=2); on the next startOfFrame the slot goes IDLE and its request stays 0.
- Pool full and cooldown: fire every 9 frames, four times with no hits. Slots 0,1,2 fill and the fourth shot is lost (no shotFired). A fire edge 3 frames after a spawn is ignored.
- Hit precedence: slot 0 FLYING, hit=3'b001 together with startOfFrame and pending set. Slot 0 goes IDLE, the spawn goes to slot 1, and slot 0's request is 0 two cycles later.
- Clamp and mid-flight reset: shooterX=630 spawns at x=636. Asserting resetN low mid-frame clears all slots and outputs on the next edge.

Source files
------------

// File: rtl/bullets_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bullets_pkg
// Brief    : Shared constants and slot record for the player bullet pool.
// Revision : 1.0
// ============================================================================
package bullets_pkg;

    localparam int NUM_BULLETS = 3;
    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;

    localparam logic [7:0] DEFAULT_COLOR = 8'hFC;

    typedef struct packed {
        logic        active;
        logic [10:0] x;
        logic [10:0] y;
    } slot_t;

endpackage
`default_nettype wire

// File: rtl/bullet_slot.sv
`default_nettype none
// ============================================================================
// Module   : bullet_slot
// Brief    : One bullet: spawn, per-frame move, top exit, hit retire, box test.
// Revision : 1.0
// ============================================================================
module bullet_slot
    import bullets_pkg::*;
#(
    parameter int BULLET_W = 4,
    parameter int BULLET_H = 8,
    parameter int SPEED    = 4
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        i_start_of_frame,
    input  logic        i_hit,
    input  logic        i_spawn,
    input  logic [10:0] i_spawn_x,
    input  logic [10:0] i_spawn_y,
    input  logic [10:0] i_pixel_x,
    input  logic [10:0] i_pixel_y,
    output logic        o_active,
    output logic        o_in_box
);

    slot_t r_slot;

    // Spawn is only ever steered to an idle slot, so it cannot be masked by a hit.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_slot <= '0;
        end else if (i_spawn) begin
            r_slot <= '{active: 1'b1, x: i_spawn_x, y: i_spawn_y};
        end else if (i_hit) begin
            r_slot.active <= 1'b0;
        end else if (i_start_of_frame && r_slot.active) begin
            if (r_slot.y >= 11'(SPEED)) begin
                r_slot.y <= r_slot.y - 11'(SPEED);
            end else begin
                r_slot.active <= 1'b0;
            end
        end
    end

    logic [11:0] w_px;
    logic [11:0] w_py;
    logic [11:0] w_x;
    logic [11:0] w_y;

    assign w_px = {1'b0, i_pixel_x};
    assign w_py = {1'b0, i_pixel_y};
    assign w_x  = {1'b0, r_slot.x};
    assign w_y  = {1'b0, r_slot.y};

    assign o_active = r_slot.active;
    assign o_in_box = r_slot.active
                    && (w_px >= w_x) && (w_px < w_x + 12'(BULLET_W))
                    && (w_py >= w_y) && (w_py < w_y + 12'(BULLET_H));

endmodule
`default_nettype wire

// File: rtl/bullets_pool.sv
`default_nettype none
// ============================================================================
// Module   : bullets_pool
// Brief    : Three-slot player bullet pool with fire cooldown and draw requests.
// Revision : 1.0
// ============================================================================
module bullets_pool
    import bullets_pkg::*;
#(
    parameter int         BULLET_W        = 4,
    parameter int         BULLET_H        = 8,
    parameter int         SPEED           = 4,
    parameter int         X_OFFSET        = 14,
    parameter int         COOLDOWN_FRAMES = 8,
    parameter logic [7:0] BULLET_COLOR    = DEFAULT_COLOR
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic                   fire,
    input  logic [10:0]            shooterX,
    input  logic [10:0]            shooterY,
    input  logic [10:0]            pixelX,
    input  logic [10:0]            pixelY,
    input  logic [NUM_BULLETS-1:0] hit,
    output logic [NUM_BULLETS-1:0] bulletDrawingRequest,
    output logic [7:0]             bulletRGB,
    output logic                   shotFired
);

    localparam int          CD_W   = $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [11:0] X_MAX  = 12'(SCREEN_W - BULLET_W);

    logic                   r_fire_d;
    logic                   r_pending;
    logic [CD_W-1:0]        r_cooldown;
    logic [NUM_BULLETS-1:0] w_active;
    logic [NUM_BULLETS-1:0] w_in_box;
    logic [NUM_BULLETS-1:0] w_spawn_sel;
    logic                   w_free;
    logic                   w_spawn;
    logic [11:0]            w_sum_x;
    logic [10:0]            w_spawn_x;
    logic [10:0]            w_spawn_y;

    always_comb begin
        w_spawn_sel = '0;
        w_free      = 1'b0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (!w_active[i] && !w_free) begin
                w_spawn_sel[i] = 1'b1;
                w_free         = 1'b1;
            end
        end
    end

    assign w_spawn   = startOfFrame && r_pending && w_free;
    assign w_sum_x   = {1'b0, shooterX} + 12'(X_OFFSET);
    assign w_spawn_x = (w_sum_x > X_MAX) ? X_MAX[10:0] : w_sum_x[10:0];
    assign w_spawn_y = (shooterY < 11'(BULLET_H)) ? 11'd0 : shooterY - 11'(BULLET_H);

    generate
        for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
            bullet_slot #(
                .BULLET_W (BULLET_W),
                .BULLET_H (BULLET_H),
                .SPEED    (SPEED)
            ) u_slot (
                .clk              (clk),
                .resetN           (resetN),
                .i_start_of_frame (startOfFrame),
                .i_hit            (hit[g]),
                .i_spawn          (w_spawn && w_spawn_sel[g]),
                .i_spawn_x        (w_spawn_x),
                .i_spawn_y        (w_spawn_y),
                .i_pixel_x        (pixelX),
                .i_pixel_y        (pixelY),
                .o_active         (w_active[g]),
                .o_in_box         (w_in_box[g])
            );
        end
    endgenerate

    // A frame boundary always consumes the pending request, spawn or not.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_fire_d             <= 1'b0;
            r_pending            <= 1'b0;
            r_cooldown           <= '0;
            bulletDrawingRequest <= '0;
            bulletRGB            <= 8'h00;
            shotFired            <= 1'b0;
        end else begin
            r_fire_d <= fire;
            if (startOfFrame) begin
                r_pending <= 1'b0;
            end else if (fire && !r_fire_d && (r_cooldown == '0)) begin
                r_pending <= 1'b1;
            end
            if (w_spawn) begin
                r_cooldown <= CD_W'(COOLDOWN_FRAMES);
            end else if (startOfFrame && (r_cooldown != '0)) begin
                r_cooldown <= r_cooldown - 1'b1;
            end
            bulletDrawingRequest <= w_in_box;
            bulletRGB            <= (|w_in_box) ? BULLET_COLOR : 8'h00;
            shotFired            <= w_spawn;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bullets_pool.sv
`default_nettype none
// ============================================================================
// Module   : tb_bullets_pool
// Brief    : Directed stimulus with a cycle-stamped scoreboard for bullets_pool.
// Revision : 1.0
// ============================================================================
module tb_bullets_pool;

    logic        clk;
    logic        resetN;
    logic        startOfFrame;
    logic        fire;
    logic [10:0] shooterX;
    logic [10:0] shooterY;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic [2:0]  hit;
    logic [2:0]  bulletDrawingRequest;
    logic [7:0]  bulletRGB;
    logic        shotFired;

    bullets_pool dut (
        .clk                  (clk),
        .resetN               (resetN),
        .startOfFrame         (startOfFrame),
        .fire                 (fire),
        .shooterX             (shooterX),
        .shooterY             (shooterY),
        .pixelX               (pixelX),
        .pixelY               (pixelY),
        .hit                  (hit),
        .bulletDrawingRequest (bulletDrawingRequest),
        .bulletRGB            (bulletRGB),
        .shotFired            (shotFired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         cyc;
        logic [2:0] req;
        logic [7:0] rgb;
        logic       shot;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every queued expectation is due right after its target edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_vec++;
            if (e.cyc != cyc || bulletDrawingRequest !== e.req
                || bulletRGB !== e.rgb || shotFired !== e.shot) begin
                n_err++;
                $display("FAIL %s: got req=%b rgb=%h shot=%b, want req=%b rgb=%h shot=%b (cycle %0d/%0d)",
                         e.name, bulletDrawingRequest, bulletRGB, shotFired,
                         e.req, e.rgb, e.shot, cyc, e.cyc);
            end
        end
    end

    localparam logic [10:0] PARK_X = 11'd700;
    localparam logic [10:0] PARK_Y = 11'd500;

    task automatic drive(input logic s, input logic [2:0] h, input logic [10:0] px,
                         input logic [10:0] py, input logic [2:0] er, input logic es,
                         input string nm);
        exp_t e;
        startOfFrame = s;
        hit          = h;
        pixelX       = px;
        pixelY       = py;
        e.cyc  = cyc + 1;
        e.req  = er;
        e.rgb  = (er != 3'b000) ? 8'hFC : 8'h00;
        e.shot = es;
        e.name = nm;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic sof(input logic es, input string nm);
        drive(1'b1, 3'b000, PARK_X, PARK_Y, 3'b000, es, nm);
    endtask

    task automatic probe(input logic [10:0] px, input logic [10:0] py,
                         input logic [2:0] er, input string nm);
        drive(1'b0, 3'b000, px, py, er, 1'b0, nm);
    endtask

    task automatic fire_edge();
        fire = 1'b1;
        drive(1'b0, 3'b000, PARK_X, PARK_Y, 3'b000, 1'b0, "fire_hi");
        fire = 1'b0;
        drive(1'b0, 3'b000, PARK_X, PARK_Y, 3'b000, 1'b0, "fire_lo");
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        drive(1'b0, 3'b000, PARK_X, PARK_Y, 3'b000, 1'b0, "reset");
        drive(1'b0, 3'b000, PARK_X, PARK_Y, 3'b000, 1'b0, "reset");
        resetN = 1'b1;
    endtask

    task automatic check_idle(input string nm);
        n_vec++;
        if (bulletDrawingRequest !== 3'b000 || bulletRGB !== 8'h00
            || shotFired !== 1'b0) begin
            n_err++;
            $display("FAIL %s: outputs not in reset state: req=%b rgb=%h shot=%b",
                     nm, bulletDrawingRequest, bulletRGB, shotFired);
        end
    endtask

    initial begin
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        fire         = 1'b0;
        shooterX     = '0;
        shooterY     = '0;
        pixelX       = PARK_X;
        pixelY       = PARK_Y;
        hit          = '0;
        @(negedge clk);

        // Reset, idle frames, first spawn at (314,392)
        do_reset();
        check_idle("reset_state");
        sof(1'b0, "idle_sof");
        sof(1'b0, "idle_sof");
        probe(11'd314, 11'd392, 3'b000, "idle_probe");
        shooterX = 11'd300;
        shooterY = 11'd400;
        fire_edge();
        sof(1'b1, "spawn0");
        probe(11'd314, 11'd392, 3'b001, "s0_topleft");
        probe(11'd317, 11'd399, 3'b001, "s0_botright");
        probe(11'd318, 11'd392, 3'b000, "s0_right_edge");
        probe(11'd314, 11'd400, 3'b000, "s0_below");
        probe(11'd313, 11'd392, 3'b000, "s0_left_edge");

        // Ten frames of flight: y = 392 - 40 = 352
        repeat (10) sof(1'b0, "flight_sof");
        probe(11'd315, 11'd355, 3'b001, "fly_in");
        probe(11'd318, 11'd355, 3'b000, "fly_out_x");
        probe(11'd315, 11'd351, 3'b000, "fly_above");

        // Top exit: slot 1 spawns at y=2, slot 0 keeps flying
        shooterY = 11'd10;
        fire_edge();
        sof(1'b1, "spawn_top");
        probe(11'd315, 11'd3, 3'b010, "top_in");
        sof(1'b0, "top_exit_sof");
        probe(11'd315, 11'd3, 3'b000, "top_gone");
        probe(11'd315, 11'd344, 3'b001, "s0_still");

        // Pool full and cooldown
        do_reset();
        shooterX = 11'd100;
        shooterY = 11'd400;
        fire_edge();
        sof(1'b1, "pool_s0");
        repeat (3) sof(1'b0, "cool_sof");
        fire_edge();
        repeat (5) sof(1'b0, "cool_ignored");
        fire_edge();
        sof(1'b1, "pool_s1");
        repeat (8) sof(1'b0, "cool_sof");
        fire_edge();
        sof(1'b1, "pool_s2");
        repeat (8) sof(1'b0, "cool_sof");
        fire_edge();
        sof(1'b0, "pool_lost");
        probe(11'd114, 11'd284, 3'b001, "pool_slot0");
        probe(11'd114, 11'd320, 3'b010, "pool_slot1");
        probe(11'd117, 11'd363, 3'b100, "pool_slot2");

        // Hit between frames: request drops two cycles after hit
        drive(1'b0, 3'b010, 11'd114, 11'd320, 3'b010, 1'b0, "hit_n1");
        probe(11'd114, 11'd320, 3'b000, "hit_n2");

        // Hit on slot 0 with spawn in the same frame: spawn goes to slot 1
        fire_edge();
        drive(1'b1, 3'b001, 11'd114, 11'd284, 3'b001, 1'b1, "hit_spawn");
        probe(11'd114, 11'd284, 3'b000, "hit0_gone");
        probe(11'd114, 11'd392, 3'b010, "spawn_slot1");
        probe(11'd114, 11'd352, 3'b100, "slot2_moved");

        // Clamp on x, saturation on y
        do_reset();
        shooterX = 11'd630;
        shooterY = 11'd5;
        fire_edge();
        sof(1'b1, "clamp_spawn");
        probe(11'd636, 11'd0, 3'b001, "clamp_tl");
        probe(11'd639, 11'd7, 3'b001, "clamp_br");
        probe(11'd635, 11'd0, 3'b000, "clamp_left");
        probe(11'd636, 11'd8, 3'b000, "clamp_below");

        // Mid-flight reset clears outputs and slots on the edge
        resetN = 1'b0;
        drive(1'b0, 3'b000, 11'd636, 11'd0, 3'b000, 1'b0, "rst_mid");
        check_idle("rst_mid_state");
        resetN = 1'b1;
        probe(11'd636, 11'd0, 3'b000, "rst_after");
        sof(1'b0, "rst_no_shot");

        fork
            wait (sb.size() == 0);
            repeat (20) @(posedge clk);
        join_any
        disable fork;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations still pending after timeout", sb.size());
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        if (n_err == 0) $display("PASS");
        else            $display("FAIL");
        $finish;
    end

endmodule
`default_nettype wire
